video_sig_gen: RTL and testbench

//   Pixel-clock timing generator driving the HDMI TX path. Produces raster

---
 rtl/video_sig_gen.sv | 112 +++++++++++
 tb/tb_video_sig_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/video_sig_gen.sv
// video_sig_gen
//   Pixel-clock raster timing generator for the HDMI TX path. Walks an
//   (hcount, vcount) raster and produces active-draw, hsync, vsync, a
//   one-cycle new-frame strobe and a frame counter.
//
//   All outputs are registered. Flags are decoded from the *next* counter
//   values, so they line up with the counters in the same cycle.
//
// Ports
//   clk_in      in   1   pixel clock
//   rst_in      in   1   synchronous active-high reset
//   hcount_out  out  11  horizontal position, 0..H_TOTAL-1
//   vcount_out  out  10  vertical position, 0..V_TOTAL-1
//   vs_out      out  1   vertical sync, active-high
//   hs_out      out  1   horizontal sync, active-high
//   ad_out      out  1   current pixel is in the visible area
//   nf_out      out  1   new-frame strobe at (ACTIVE_H_PIXELS, ACTIVE_LINES)
//   fc_out      out  6   frame count, 0..FPS-1
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FPS             = 60
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        vs_out,
  output logic        hs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(ACTIVE_H_PIXELS);
  localparam logic [10:0] HS_ON  = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [10:0] HS_OFF = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);

  localparam logic [9:0]  V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(ACTIVE_LINES);
  localparam logic [9:0]  VS_ON  = 10'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [9:0]  VS_OFF = 10'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

  localparam logic [5:0]  FC_MAX = 6'(FPS - 1);

  logic [10:0] r_h;
  logic [9:0]  r_v;
  logic        r_vs, r_hs, r_ad, r_nf;
  logic [5:0]  r_fc;

  logic [10:0] w_h_next;
  logic [9:0]  w_v_next;
  logic        w_ad_next, w_hs_next, w_vs_next, w_nf_next;

  always_comb begin
    w_h_next = r_h + 11'd1;
    w_v_next = r_v;
    if (r_h == H_MAX) begin
      w_h_next = 11'd0;
      w_v_next = (r_v == V_MAX) ? 10'd0 : r_v + 10'd1;
    end
  end

  // Decode from next counters so registered flags match registered counters.
  assign w_ad_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);
  assign w_hs_next = (w_h_next >= HS_ON) && (w_h_next < HS_OFF);
  assign w_vs_next = (w_v_next >= VS_ON) && (w_v_next < VS_OFF);
  assign w_nf_next = (w_h_next == H_ACT) && (w_v_next == V_ACT);

  // Reset parks the raster on its last pixel so the first free-running edge
  // lands on (0,0) and frame 0 loses no pixel.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_h  <= H_MAX;
      r_v  <= V_MAX;
      r_vs <= 1'b0;
      r_hs <= 1'b0;
      r_ad <= 1'b0;
      r_nf <= 1'b0;
      r_fc <= 6'd0;
    end else begin
      r_h  <= w_h_next;
      r_v  <= w_v_next;
      r_vs <= w_vs_next;
      r_hs <= w_hs_next;
      r_ad <= w_ad_next;
      r_nf <= w_nf_next;
      if (w_nf_next) begin
        r_fc <= (r_fc == FC_MAX) ? 6'd0 : r_fc + 6'd1;
      end
    end
  end

  assign hcount_out = r_h;
  assign vcount_out = r_v;
  assign vs_out     = r_vs;
  assign hs_out     = r_hs;
  assign ad_out     = r_ad;
  assign nf_out     = r_nf;
  assign fc_out     = r_fc;

endmodule

// File: tb/tb_video_sig_gen.sv
// Scoreboarded bench for video_sig_gen using a reduced raster so that many
// frames, fc wrap and a mid-frame reset fit in a short run.
//   H: 16 active, 3 fp, 4 sync, 5 bp -> 28 total, hs on hcount 19..22
//   V: 10 active, 2 fp, 3 sync, 4 bp -> 19 total, vs on vcount 12..14
//   FPS 4, nf at (16,10)
module tb_video_sig_gen;

  localparam int AH = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int AL = 10, VFP = 2, VSW = 3, VBP = 4;
  localparam int FPS = 4;
  localparam int HT = 28;
  localparam int VT = 19;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        vs_out, hs_out, ad_out, nf_out;
  logic [5:0]  fc_out;

  video_sig_gen #(
    .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .FPS(FPS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .vs_out(vs_out), .hs_out(hs_out), .ad_out(ad_out),
    .nf_out(nf_out), .fc_out(fc_out)
  );

  always #5 clk_in = ~clk_in;

  // {h[10:0], v[9:0], vs, hs, ad, nf, fc[5:0]}
  logic [30:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int model_nf_cnt = 0;
  int dut_nf_cnt = 0;
  int model_wraps = 0;
  bit started = 1'b0;

  int mh, mv, mfc;
  bit mvs, mhs, mad, mnf;

  task automatic model_step(input bit r);
    if (r) begin
      mh = HT - 1; mv = VT - 1; mfc = 0;
      mvs = 0; mhs = 0; mad = 0; mnf = 0;
    end else begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      mad = (mh < AH) && (mv < AL);
      mhs = (mh >= 19) && (mh <= 22);
      mvs = (mv >= 12) && (mv <= 14);
      mnf = (mh == 16) && (mv == 10);
      if (mnf) begin
        model_nf_cnt++;
        if (mfc == FPS - 1) begin
          mfc = 0;
          model_wraps++;
        end else begin
          mfc = mfc + 1;
        end
      end
    end
  endtask

  task automatic drive(input bit r);
    @(negedge clk_in);
    rst_in = r;
    model_step(r);
    exp_q.push_back({11'(mh), 10'(mv), mvs, mhs, mad, mnf, 6'(mfc)});
    started = 1'b1;
  endtask

  // Monitor: every cycle presents an output, compare just after the edge.
  initial begin
    logic [30:0] got, exp;
    forever begin
      @(posedge clk_in);
      #1;
      if (started) begin
        got = {hcount_out, vcount_out, vs_out, hs_out, ad_out, nf_out, fc_out};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL raster: output with no expected entry, got h=%0d v=%0d", hcount_out, vcount_out);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL raster: got h=%0d v=%0d vs=%b hs=%b ad=%b nf=%b fc=%0d, exp h=%0d v=%0d vs=%b hs=%b ad=%b nf=%b fc=%0d",
                     got[30:20], got[19:10], got[9], got[8], got[7], got[6], got[5:0],
                     exp[30:20], exp[19:10], exp[9], exp[8], exp[7], exp[6], exp[5:0]);
          end
        end
        checks++;
        if (ad_out && hs_out) begin
          errors++;
          $display("FAIL ad_hs_overlap: got ad=1 hs=1 at h=%0d v=%0d, exp not both 1", hcount_out, vcount_out);
        end
        checks++;
        if (ad_out && vs_out) begin
          errors++;
          $display("FAIL ad_vs_overlap: got ad=1 vs=1 at h=%0d v=%0d, exp not both 1", hcount_out, vcount_out);
        end
        if (nf_out === 1'b1) dut_nf_cnt++;
      end
    end
  end

  initial begin
    bit did_rst;
    did_rst = 1'b0;
    mh = 0; mv = 0; mfc = 0; mvs = 0; mhs = 0; mad = 0; mnf = 0;

    repeat (3) drive(1'b1);

    // Run until the mid-frame reset point in frame count 2, then reset once.
    for (int i = 0; i < 4 * HT * VT; i++) begin
      if (!did_rst && mfc == 2 && mh == 9 && mv == 5) begin
        drive(1'b1);
        did_rst = 1'b1;
      end else begin
        drive(1'b0);
      end
    end

    // Enough frames after the reset to wrap fc (FPS=4) at least once more.
    for (int i = 0; i < 6 * HT * VT; i++) drive(1'b0);

    @(negedge clk_in);

    checks++;
    if (!did_rst) begin
      errors++;
      $display("FAIL mid_frame_reset: got not applied, exp applied");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    checks++;
    if (dut_nf_cnt != model_nf_cnt) begin
      errors++;
      $display("FAIL nf_count: got %0d, exp %0d", dut_nf_cnt, model_nf_cnt);
    end
    checks++;
    if (model_wraps < 1) begin
      errors++;
      $display("FAIL fc_wrap_coverage: got %0d wraps, exp >=1", model_wraps);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
